// File: rtl/ee457_pkg.sv
// Shared definitions for the ee457 instruction cache.
// Holds the refill FSM encoding and the address-field width helpers.
package ee457_pkg;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_REFILL = 1'b1
    } state_e;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Tag is everything above the byte, word and index fields.
    function automatic int tag_w(input int addr_w, input int words,
                                 input int lines);
        return addr_w - $clog2(words) - $clog2(lines) - 2;
    endfunction

endpackage

// File: rtl/ee457_icache_tagram.sv
// Tag and valid storage for the direct-mapped icache.
// Combinational lookup; clear-all wins over a same-cycle set.
module ee457_icache_tagram #(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_all,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [TAG_W-1:0] set_tag,
    input  logic [IDX_W-1:0] lk_idx,
    input  logic [TAG_W-1:0] lk_tag,
    output logic             hit
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_q [LINES];

    always_comb begin
        valid_d = valid_q;
        if (set_en) begin
            valid_d[set_idx] = 1'b1;
        end
        if (clr_all) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (set_en) begin
            tag_q[set_idx] <= set_tag;
        end
    end

    assign hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

endmodule

// File: rtl/ee457_icache.sv
// Direct-mapped read-only instruction cache with a line-refill FSM.
// Hits return data combinationally; misses stall the fetch stage.
module ee457_icache
    import ee457_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    input  logic              inv,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_valid,
    output logic              refill_busy
);

    localparam int OFF_W = off_w(WORDS);
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(ADDR_W, WORDS, LINES);
    localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS - 1);

    state_e           state_q, state_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] mtag_q, mtag_d;
    logic [IDX_W-1:0] midx_q, midx_d;
    logic             abort_q, abort_d;

    logic [31:0]      data_q [LINES][WORDS];

    logic [OFF_W-1:0] a_word;
    logic [IDX_W-1:0] a_idx;
    logic [TAG_W-1:0] a_tag;
    logic             hit;
    logic             data_we;
    logic             set_en;
    logic             unused_byte;

    assign a_word      = cpu_addr[OFF_W+1:2];
    assign a_idx       = cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
    assign a_tag       = cpu_addr[ADDR_W-1:OFF_W+IDX_W+2];
    assign unused_byte = ^cpu_addr[1:0];

    ee457_icache_tagram #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tagram (
        .clk     (clk),
        .rst     (rst),
        .clr_all (inv),
        .set_en  (set_en && !rst),
        .set_idx (midx_q),
        .set_tag (mtag_q),
        .lk_idx  (a_idx),
        .lk_tag  (a_tag),
        .hit     (hit)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mtag_d      = mtag_q;
        midx_d      = midx_q;
        abort_d     = abort_q;
        cpu_ready   = 1'b0;
        mem_rd      = 1'b0;
        refill_busy = 1'b0;
        data_we     = 1'b0;
        set_en      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cpu_ready = !cpu_rd || hit;
                abort_d   = 1'b0;
                if (cpu_rd && !hit) begin
                    mtag_d  = a_tag;
                    midx_d  = a_idx;
                    cnt_d   = '0;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                mem_rd      = 1'b1;
                refill_busy = 1'b1;
                if (inv) begin
                    abort_d = 1'b1;
                end
                if (mem_valid) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    // An invalidate on the last beat also kills the line.
                    if (cnt_q == LAST) begin
                        set_en  = !abort_q && !inv;
                        cnt_d   = '0;
                        abort_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mtag_q  <= '0;
            midx_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mtag_q  <= mtag_d;
            midx_q  <= midx_d;
            abort_q <= abort_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we && !rst) begin
            data_q[midx_q][cnt_q] <= mem_rdata;
        end
    end

    assign mem_addr  = {mtag_q, midx_q, cnt_q, 2'b00};
    assign cpu_rdata = data_q[a_idx][a_word];

endmodule

// File: doc/ee457_icache.md
Name: ee457_icache

Overview:
Direct-mapped, read-only instruction cache. Sits between the pipelined CPU's instruction-fetch port (imem_addr/imem_rdata) and a multi-cycle backing instruction memory. A hit returns the instruction combinationally in the same cycle. A miss deasserts cpu_ready, so the fetch and decode stages stall, and runs a line-refill FSM against the backing memory.

Parameters:
LINES, 16, number of cache lines (power of 2, >=2)
WORDS, 4, 32-bit words per line (power of 2, >=2)
ADDR_W, 32, byte-address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
cpu_addr  in  ADDR_W  fetch byte address (the CPU's pc)
cpu_rd  in  1  fetch request
cpu_rdata  out  32  instruction; valid when cpu_ready=1 and cpu_rd=1
cpu_ready  out  1  1 = hit or idle; 0 = stall the fetch stage
inv  in  1  pulse: invalidate the whole cache
mem_addr  out  ADDR_W  backing-memory word address, byte-aligned, bits[1:0]=0
mem_rd  out  1  backing read request, held until mem_valid
mem_rdata  in  32  backing read data
mem_valid  in  1  mem_rdata valid this cycle; one word per pulse
refill_busy  out  1  FSM is in REFILL (debug/perf)

Behaviour:
- Address split, with OFF=log2(WORDS) and IDX=log2(LINES):
  - bits[1:0] ignored
  - word = [OFF+1:2]
  - index = [OFF+IDX+1:OFF+2]
  - tag = remaining upper bits
- Storage: data array LINES x WORDS x 32, tag array, valid bit per line. Only the valid bits are reset.
- Reset (rst=1 at a clk edge): all valid bits cleared; FSM=IDLE; word counter=0; mem_rd=0; refill_busy=0. Combinationally after reset, cpu_ready=1 while cpu_rd=0. cpu_rdata is don't-care when not ready.
- hit = valid[index] && tag_arr[index]==tag (combinational).
- IDLE:
  - cpu_rd=0 -> cpu_ready=1.
  - cpu_rd=1 and hit -> cpu_ready=1, cpu_rdata=data[index][word], same cycle, zero latency.
  - cpu_rd=1 and miss -> cpu_ready=0. Next edge: latch miss tag/index into the refill registers, counter=0, go REFILL.
- REFILL:
  - cpu_ready=0; mem_rd=1; mem_addr={miss_tag,miss_index,counter,2'b00}.
  - On mem_valid: write mem_rdata to data[miss_index][counter], counter++.
  - On mem_valid with counter==WORDS-1: write tag_arr[miss_index]=miss_tag, set valid (unless aborted), counter=0, go IDLE.
  - Words are fetched in ascending order from word 0; there is no critical-word-first.
- Back in IDLE: the hit check is re-evaluated against the current cpu_addr. The first hit is delivered one cycle after the last mem_valid.
- cpu_addr and cpu_rd changes during REFILL are ignored; the refill always completes. This is the recovery path for a branch/jump redirect mid-miss.
- inv:
  - In IDLE: all valid bits cleared at the edge. cpu_ready that cycle still reflects the pre-invalidate state.
  - In REFILL: valid bits cleared and an abort flag is set. The refill finishes the remaining beats but does not set valid for that line. The flag clears on return to IDLE.
- inv coinciding with the final mem_valid: the line is not validated.
- rst mid-refill: immediate return to IDLE; mem_rd=0 in the following cycle. A late mem_valid in IDLE is ignored.
- mem_valid while mem_rd=0: ignored.
- Index wrap: a tag conflict on the same index evicts unconditionally; no replacement state.

Decomposition:
- Shared package (ee457_pkg): FSM state encodings (S_IDLE, S_REFILL); derived widths OFF_W, IDX_W, TAG_W as constant functions of the parameters.
- Sub-module ee457_icache_tagram: tag array plus valid array, with sync reset, clear-all and single-line set-valid ports, and a combinational lookup. The data array stays in the top module.

Test Plan:
1. Cold miss:
   - Stimulus: after reset, cpu_rd=1, cpu_addr=0x00000040; memory returns 0xA0..0xA3 with mem_valid every 2nd cycle.
   - Required: mem_addr steps 0x40,0x44,0x48,0x4C; cpu_ready=0 throughout REFILL; cpu_ready=1 with cpu_rdata=0xA0 one cycle after the 4th beat.
2. Hit stream:
   - Stimulus: then sequential cpu_addr 0x44,0x48,0x4C.
   - Required: cpu_ready=1 every cycle; rdata 0xA1,0xA2,0xA3; mem_rd stays 0.
3. Conflict eviction (LINES=16, WORDS=4, same index 4):
   - Stimulus: fetch 0x440 after test 1.
   - Required: miss and refill. A subsequent fetch of 0x40 misses again.
4. Redirect mid-refill:
   - Stimulus: change cpu_addr 0x80 -> 0x100 after beat 1.
   - Required: all 4 beats for 0x80 complete; the line for 0x80 becomes valid; then 0x100 misses and refills.
5. Invalidate during refill:
   - Stimulus: pulse inv on beat 2 of the 0x200 refill.
   - Required: refill completes. Re-fetching 0x200 misses; previously valid 0x40 also misses.
6. Reset mid-refill:
   - Stimulus: assert rst during beat 1.
   - Required: next cycle mem_rd=0, refill_busy=0. A stray mem_valid is ignored and no line becomes valid.
